// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment scan driver.
//   - Segment bit positions inside the 7-bit segment word (seg[6]=A .. seg[0]=G)
//   - 16-entry hex-to-segment table (active-high, 1 = segment lit)
//   - idx_width(): width of an index/counter that covers 0..n-1, minimum 1 bit
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_A = 7'(1 << SEG_A_BIT);
    localparam logic [6:0] SEG_B = 7'(1 << SEG_B_BIT);
    localparam logic [6:0] SEG_C = 7'(1 << SEG_C_BIT);
    localparam logic [6:0] SEG_D = 7'(1 << SEG_D_BIT);
    localparam logic [6:0] SEG_E = 7'(1 << SEG_E_BIT);
    localparam logic [6:0] SEG_F = 7'(1 << SEG_F_BIT);
    localparam logic [6:0] SEG_G = 7'(1 << SEG_G_BIT);

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F,          // 0
        SEG_B | SEG_C,                                          // 1
        SEG_A | SEG_B | SEG_D | SEG_E | SEG_G,                  // 2
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_G,                  // 3
        SEG_B | SEG_C | SEG_F | SEG_G,                          // 4
        SEG_A | SEG_C | SEG_D | SEG_F | SEG_G,                  // 5
        SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,          // 6
        SEG_A | SEG_B | SEG_C,                                  // 7
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,  // 8
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G,          // 9
        SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G,          // A
        SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,                  // b
        SEG_A | SEG_D | SEG_E | SEG_F,                          // C
        SEG_B | SEG_C | SEG_D | SEG_E | SEG_G,                  // d
        SEG_A | SEG_D | SEG_E | SEG_F | SEG_G,                  // E
        SEG_A | SEG_E | SEG_F | SEG_G                           // F
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to seven-segment pattern lookup.
// Ports:
//   i_nibble  in  4  hex digit 0..F
//   o_seg     out 7  segment pattern, seg[6]=A .. seg[0]=G, active-high
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS seven-segment digits. A prescaler
// produces a tick every REFRESH_DIV clocks; each tick selects the next digit
// and registers its decoded segments, decimal point and one-hot select.
// Optional leading-zero suppression blanks upper digits that are zero.
// Ports:
//   clk       in  1                 system clock, rising edge
//   rst       in  1                 asynchronous active-high reset
//   en        in  1                 display enable (0 blanks outputs at next tick)
//   load      in  1                 strobe: capture value and dp_in into shadow
//   value     in  4*NUM_DIGITS      hex nibbles, nibble k -> digit k
//   dp_in     in  NUM_DIGITS        decimal-point request per digit
//   seg       out 7                 segments A..G (seg[6]=A), registered
//   dp        out 1                 decimal point of selected digit, registered
//   digit_en  out NUM_DIGITS        one-hot digit select, registered
//   scan_idx  out idx_width(N)      index of selected digit, registered
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int LZ_BLANK    = 1
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              load,
    input  logic [4*NUM_DIGITS-1:0]           value,
    input  logic [NUM_DIGITS-1:0]             dp_in,
    output logic [6:0]                        seg,
    output logic                              dp,
    output logic [NUM_DIGITS-1:0]             digit_en,
    output logic [idx_width(NUM_DIGITS)-1:0]  scan_idx
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_scan_idx;
    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_digit_en;

    logic                    w_tick;
    logic [IDX_W-1:0]        w_next_idx;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_dec_seg;

    // Shadow registers; the output stage reads the pre-load contents on a
    // coincident load/tick edge, so a load on a tick shows one slot later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_dp    <= '0;
        end else if (load) begin
            r_value <= value;
            r_dp    <= dp_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_next_idx = (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + IDX_W'(1);

    // Select the digit about to be shown. The scan runs from the top digit
    // down so 'upper_zero' accumulates "this nibble and all above are zero".
    always_comb begin
        logic upper_zero;
        w_nibble   = '0;
        w_dp_sel   = 1'b0;
        w_blank    = 1'b0;
        w_onehot   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (r_value[4*k +: 4] == 4'd0);
            if (w_next_idx == IDX_W'(k)) begin
                w_nibble    = r_value[4*k +: 4];
                w_dp_sel    = r_dp[k];
                w_onehot[k] = 1'b1;
                w_blank     = (LZ_BLANK != 0) && (k != 0) && upper_zero;
            end
        end
    end

    seg7_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    // Outputs only move on a tick, so each digit holds stable for a full slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_idx <= '0;
            r_seg      <= '0;
            r_dp_out   <= 1'b0;
            r_digit_en <= '0;
        end else if (w_tick) begin
            r_scan_idx <= w_next_idx;
            if (en) begin
                r_seg      <= w_blank ? 7'd0 : w_dec_seg;
                r_dp_out   <= w_dp_sel;
                r_digit_en <= w_onehot;
            end else begin
                r_seg      <= '0;
                r_dp_out   <= 1'b0;
                r_digit_en <= '0;
            end
        end
    end

    assign seg      = r_seg;
    assign dp       = r_dp_out;
    assign digit_en = r_digit_en;
    assign scan_idx = r_scan_idx;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 1000: clk cycles each digit stays selected, legal range >= 1.
REQ-003 Parameter LZ_BLANK, default 1: enables leading-zero suppression when 1.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  display enable; 0 blanks all outputs, scanning continues.
REQ-007 load  in  1  single-cycle strobe; captures value and dp_in.
REQ-008 value  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 least significant.
REQ-009 dp_in  in  NUM_DIGITS  decimal-point request per digit.
REQ-010 seg  out  7  segments, seg[6]=A .. seg[0]=G, active-high, registered.
REQ-011 dp  out  1  decimal point of the selected digit, active-high, registered.
REQ-012 digit_en  out  NUM_DIGITS  one-hot digit select, active-high, registered.
REQ-013 scan_idx  out  clog2(NUM_DIGITS), minimum 1 bit  index of the selected digit, registered.

Function
REQ-014 Shadow registers for value and dp_in SHALL update on the rising edge where load=1; with load=0 the shadow holds.
REQ-015 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap, issuing a tick on the cycle the count equals REFRESH_DIV-1; REFRESH_DIV=1 ticks every cycle.
REQ-016 On each tick, scan_idx SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0; NUM_DIGITS=1 holds scan_idx at 0.
REQ-017 seg, dp and digit_en SHALL be registered on the same tick edge from the shadow nibble at the new scan_idx, so outputs change only at digit boundaries.
REQ-018 A load between ticks SHALL become visible at the next tick; a load coincident with a tick SHALL NOT be visible until the following tick.
REQ-019 Hex decode, segments lit: 0 ABCDEF, 1 BC, 2 ABDEG, 3 ABCDG, 4 BCFG, 5 ACDFG, 6 ACDEFG, 7 ABC, 8 ABCDEFG, 9 ABCDFG, A ABCEFG, b CDEFG, C ADEF, d BCDEG, E ADEFG, F AEFG.
REQ-020 With LZ_BLANK=1, digit k>0 SHALL show seg=0 when shadow nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never suppressed.
REQ-021 dp SHALL equal the shadow dp bit of the selected digit, including on zero-suppressed digits.
REQ-022 digit_en SHALL stay one-hot at scan_idx even when seg=0 due to suppression.
REQ-023 en=0 SHALL force seg, dp and digit_en to 0 at the next tick; prescaler, scan_idx and shadow keep running.

Reset
REQ-024 rst=1 SHALL immediately clear prescaler, scan_idx, shadow value, shadow dp, seg, dp and digit_en to 0, regardless of clk.
REQ-025 After rst falls, the first tick SHALL occur REFRESH_DIV rising edges later and select digit 1 (digit 0 when NUM_DIGITS=1).
REQ-026 rst asserted mid-scan SHALL abandon the current digit; no partial state is retained.

Structure
REQ-027 The 16-entry hex-to-segment table and segment bit-position constants SHALL live in shared package seg7_pkg.
REQ-028 Decoding SHALL be a sub-module, seg7_hex_decode (4-bit in, 7-bit out, combinational), instantiated once on the muxed nibble.

Verification
REQ-029 NUM_DIGITS=4, REFRESH_DIV=4: rst, then load value=16'h1234, en=1 -> digit_en sequence 0010,0100,1000,0001 every 4 cycles; digit 0 shows seg=7'b0110011 (4).
REQ-030 Load 16'h0007, LZ_BLANK=1 -> digits 3..1 seg=0 with digit_en still cycling; digit 0 seg=7'b1110000 (7); load 16'h0000 -> digit 0 shows 0 (7'b1111110).
REQ-031 Load 16'h00A0, dp_in=4'b0100 -> digit 2 seg=0 with dp=1; digit 1 shows A (7'b1110111).
REQ-032 Load asserted on a tick cycle -> old value displayed for one full slot, new value from the next tick.
REQ-033 en=0 for 10 slots, then en=1 -> outputs 0 during blanking; scan_idx on resume equals the free-running count.
REQ-034 rst pulse of 2 ns between clk edges mid-scan -> all outputs 0 immediately; first tick REFRESH_DIV cycles after release; full decode sweep 0..F matches REQ-019.
